// File: rtl/adxl362_pkg.sv
// Shared constants for the ADXL362 sample FIFO: mode encodings, channel tags,
// serialiser states, output word layout and the channel-select helper.
package adxl362_pkg;

    localparam logic [1:0] MODE_OFF    = 2'b00;
    localparam logic [1:0] MODE_OLDEST = 2'b01;
    localparam logic [1:0] MODE_STREAM = 2'b10;
    localparam logic [1:0] MODE_TRIG   = 2'b11;

    localparam logic [1:0] TAG_X = 2'b00;
    localparam logic [1:0] TAG_Y = 2'b01;
    localparam logic [1:0] TAG_Z = 2'b10;
    localparam logic [1:0] TAG_T = 2'b11;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_WRITE = 1'b1;

    localparam int TAG_W   = 2;
    localparam int FIELD_W = 14;
    localparam int WORD_W  = TAG_W + FIELD_W;

    // Index of the lowest set bit; the serialiser emits channels in ascending order.
    function automatic logic [1:0] first_chan(input logic [3:0] m);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/adxl362_fifo_ram.sv
// DEPTH x WIDTH simple dual-port storage with a registered, read-before-write
// output port, so a full-FIFO read and write to the same slot returns the old word.
module adxl362_fifo_ram #(
    parameter int DEPTH = 512,
    parameter int AW    = 9,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] rdata_r;

    // Storage write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read port; holds its value when no read is requested
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rdata_r <= {WIDTH{1'b0}};
        end else if (re) begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/adxl362_sample_fifo.sv
// Multi-channel tagged sample FIFO with ADXL362 FIFO modes. Define
// ADXL362_FIFO_TRIGGER_EN to enable triggered-mode capture; otherwise mode 11 acts as stream.
module adxl362_sample_fifo
    import adxl362_pkg::*;
#(
    parameter int NUM_CHANNELS = 4,
    parameter int DATA_WIDTH   = 12,
    parameter int DEPTH        = 512,
    localparam int CNT_W       = $clog2(DEPTH + 1)
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               sample_valid,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] sample_data,
    input  logic [NUM_CHANNELS-1:0]            chan_mask,
    input  logic [1:0]                         fifo_mode,
    input  logic                               trigger,
    input  logic [CNT_W-1:0]                   watermark,
    input  logic                               rd_en,
    output logic [15:0]                        rd_data,
    output logic                               rd_valid,
    output logic [CNT_W-1:0]                   entries,
    output logic                               watermark_hit,
    output logic                               fifo_full,
    output logic                               fifo_overrun,
    output logic                               sample_drop,
    output logic                               busy
);

    localparam int AW = $clog2(DEPTH);

    logic [0:0]                         state_r;
    logic [NUM_CHANNELS*DATA_WIDTH-1:0] data_r;
    logic [NUM_CHANNELS-1:0]            mask_r;
    logic [AW-1:0]                      wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]                   count_r;
    logic [1:0]                         mode_prev_r;
    logic overrun_r, trig_r, hit_r, full_r, drop_r, rd_valid_r;

    logic                    flush_s, mode_chg_s, wr_req_s, full_s, rd_acc_s, stream_s;
    logic                    lost_s, discard_s, store_s, trig_evt_s, keep_s, ovr_set_s, accept_s;
    logic [1:0]              sel_s;
    logic [DATA_WIDTH-1:0]   chan_s;
    logic [FIELD_W-1:0]      ext_s;
    logic [WORD_W-1:0]       word_s;
    logic [NUM_CHANNELS-1:0] mask_rest_s;
    logic [AW-1:0]           wr_ptr_n_s, rd_ptr_step_s, rd_ptr_n_s;
    logic [CNT_W-1:0]        count_step_s, count_n_s;

    // Word formation, full-FIFO policy, trigger trimming and next pointer/occupancy values
    always_comb begin
        flush_s     = (fifo_mode == MODE_OFF);
        mode_chg_s  = (fifo_mode != mode_prev_r);
        accept_s    = (state_r == ST_IDLE) && sample_valid && !flush_s &&
                      (chan_mask != {NUM_CHANNELS{1'b0}});
        sel_s       = first_chan(4'(mask_r));
        chan_s      = data_r[int'(sel_s) * DATA_WIDTH +: DATA_WIDTH];
        ext_s       = FIELD_W'(signed'(chan_s));
        word_s      = {sel_s, ext_s};
        mask_rest_s = mask_r & (mask_r - NUM_CHANNELS'(1'b1));

        wr_req_s  = (state_r == ST_WRITE) && !flush_s;
        full_s    = (count_r == CNT_W'(DEPTH));
        rd_acc_s  = rd_en && (count_r != {CNT_W{1'b0}}) && !flush_s;
        stream_s  = (fifo_mode == MODE_STREAM) || ((fifo_mode == MODE_TRIG) && !trig_r);
        // A same-cycle read frees the slot, so a full write only loses data without one
        lost_s    = wr_req_s && full_s && !rd_acc_s;
        discard_s = lost_s && stream_s;
        store_s   = wr_req_s && !(lost_s && !stream_s);
`ifdef ADXL362_FIFO_TRIGGER_EN
        trig_evt_s = trigger && (fifo_mode == MODE_TRIG) && !trig_r && !mode_chg_s && !flush_s;
`else
        trig_evt_s = trigger & 1'b0;
`endif
        wr_ptr_n_s    = wr_ptr_r + AW'(store_s);
        rd_ptr_step_s = rd_ptr_r + AW'(rd_acc_s || discard_s);
        count_step_s  = count_r + CNT_W'(store_s) - CNT_W'(rd_acc_s) - CNT_W'(discard_s);
        keep_s        = trig_evt_s && (count_step_s > watermark);
        rd_ptr_n_s    = keep_s ? (wr_ptr_n_s - AW'(watermark)) : rd_ptr_step_s;
        count_n_s     = keep_s ? watermark : count_step_s;
        ovr_set_s     = lost_s || keep_s || ((state_r == ST_WRITE) && sample_valid && !flush_s);
    end

    // Serialiser: latch an accepted set, then emit one enabled channel per cycle
    always_ff @(posedge clk) begin
        if (!reset_n || flush_s) begin
            state_r <= ST_IDLE;
            mask_r  <= {NUM_CHANNELS{1'b0}};
            data_r  <= {(NUM_CHANNELS*DATA_WIDTH){1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        data_r  <= sample_data;
                        mask_r  <= chan_mask;
                        state_r <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    mask_r  <= mask_rest_s;
                    state_r <= (mask_rest_s == {NUM_CHANNELS{1'b0}}) ? ST_IDLE : ST_WRITE;
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Pointers, occupancy and status flags
    always_ff @(posedge clk) begin
        if (!reset_n || flush_s) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            overrun_r  <= 1'b0;
            trig_r     <= 1'b0;
            hit_r      <= 1'b0;
            full_r     <= 1'b0;
            drop_r     <= 1'b0;
            rd_valid_r <= 1'b0;
        end else begin
            wr_ptr_r   <= wr_ptr_n_s;
            rd_ptr_r   <= rd_ptr_n_s;
            count_r    <= count_n_s;
            overrun_r  <= ovr_set_s || (overrun_r && !rd_acc_s);
            trig_r     <= !mode_chg_s && (trig_r || trig_evt_s);
            hit_r      <= (watermark != {CNT_W{1'b0}}) && (count_n_s >= watermark);
            full_r     <= (count_n_s == CNT_W'(DEPTH));
            drop_r     <= (state_r == ST_WRITE) && sample_valid;
            rd_valid_r <= rd_acc_s;
        end
    end

    // Previous mode, used to detect switches between non-zero modes
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mode_prev_r <= MODE_OFF;
        end else begin
            mode_prev_r <= fifo_mode;
        end
    end

    adxl362_fifo_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .WIDTH (WORD_W)
    ) u_ram (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (store_s),
        .waddr   (wr_ptr_r),
        .wdata   (word_s),
        .re      (rd_acc_s),
        .raddr   (rd_ptr_r),
        .rdata   (rd_data)
    );

    assign rd_valid      = rd_valid_r;
    assign entries       = count_r;
    assign watermark_hit = hit_r;
    assign fifo_full     = full_r;
    assign fifo_overrun  = overrun_r;
    assign sample_drop   = drop_r;
    assign busy          = (state_r == ST_WRITE);

endmodule
